// File: rtl/rv32_bus_pkg.sv
// Shared types and bus widths for the rv32 unified-memory bus arbiter.
// Imported by the arbiter, its interface and the bench.
package rv32_bus_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;
    localparam int STREAK_W = 8;

    // IDLE doubles as "no owner" when the combinational owner is reported.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } rv32_bus_owner_t;

endpackage

// File: rtl/rv32_bus_arbiter_if.sv
// Bundles the core's instruction/data ports and the unified memory port
// seen by rv32_bus_arbiter.
interface rv32_bus_arbiter_if;
    import rv32_bus_pkg::*;

    // Handshake: a requester holds its request and payload stable until its
    // ready is high in the same cycle (completion). Dropping the request
    // earlier aborts it. The memory completes the presented access in any
    // cycle where mem_ready_in is high.
    logic [ADDR_W-1:0] instr_address_in;
    logic              instr_read_in;
    logic [DATA_W-1:0] instr_read_value_out;
    logic              instr_ready_out;

    logic [ADDR_W-1:0] data_address_in;
    logic              data_read_in;
    logic              data_write_in;
    logic [MASK_W-1:0] data_write_mask_in;
    logic [DATA_W-1:0] data_write_value_in;
    logic [DATA_W-1:0] data_read_value_out;
    logic              data_ready_out;

    logic [ADDR_W-1:0] mem_address_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic [MASK_W-1:0] mem_write_mask_out;
    logic [DATA_W-1:0] mem_write_value_out;
    logic [DATA_W-1:0] mem_read_value_in;
    logic              mem_ready_in;

    logic              grant_instr_out;
    logic              grant_data_out;

    // Arbiter view: it masters the shared memory port.
    modport master (
        input  instr_address_in, instr_read_in,
        output instr_read_value_out, instr_ready_out,
        input  data_address_in, data_read_in, data_write_in,
        input  data_write_mask_in, data_write_value_in,
        output data_read_value_out, data_ready_out,
        output mem_address_out, mem_read_out, mem_write_out,
        output mem_write_mask_out, mem_write_value_out,
        input  mem_read_value_in, mem_ready_in,
        output grant_instr_out, grant_data_out
    );

    // Environment view: the core buses plus the memory.
    modport slave (
        output instr_address_in, instr_read_in,
        input  instr_read_value_out, instr_ready_out,
        output data_address_in, data_read_in, data_write_in,
        output data_write_mask_in, data_write_value_in,
        input  data_read_value_out, data_ready_out,
        input  mem_address_out, mem_read_out, mem_write_out,
        input  mem_write_mask_out, mem_write_value_out,
        output mem_read_value_in, mem_ready_in,
        input  grant_instr_out, grant_data_out
    );

endinterface

// File: rtl/rv32_bus_arbiter.sv
// Arbitrates the rv32 instruction and data buses onto one memory port.
// Data wins by default; a saturating streak counter forces fetch progress.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_bus_arbiter_if.master   bus,
    output rv32_bus_owner_t      dbg_state,
    output logic [STREAK_W-1:0]  dbg_streak
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_DATA_STREAK);

    rv32_bus_owner_t       state;
    rv32_bus_owner_t       next_state;
    rv32_bus_owner_t       winner;
    rv32_bus_owner_t       owner;
    logic [STREAK_W-1:0]   streak;
    logic [STREAK_W-1:0]   streak_next;
    logic                  i_req;
    logic                  d_req;
    logic                  instr_done;
    logic                  data_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= streak_next;
        end
    end

    always_comb begin
        i_req = bus.instr_read_in;
        d_req = bus.data_read_in | bus.data_write_in;

        winner = IDLE;
        if (i_req && streak == MAX_STREAK) begin
            winner = OWN_I;
        end else if (d_req) begin
            winner = OWN_D;
        end else if (i_req) begin
            winner = OWN_I;
        end

        // Arbitration only happens between transactions; a locked owner keeps
        // the port so the address cannot change under a busy memory.
        owner = (state == IDLE) ? winner : state;

        bus.mem_address_out     = '0;
        bus.mem_read_out        = 1'b0;
        bus.mem_write_out       = 1'b0;
        bus.mem_write_mask_out  = '0;
        bus.mem_write_value_out = '0;
        case (owner)
            OWN_I: begin
                bus.mem_address_out = bus.instr_address_in;
                bus.mem_read_out    = bus.instr_read_in;
            end
            OWN_D: begin
                bus.mem_address_out     = bus.data_address_in;
                bus.mem_read_out        = bus.data_read_in;
                bus.mem_write_out       = bus.data_write_in;
                bus.mem_write_mask_out  = bus.data_write_mask_in;
                bus.mem_write_value_out = bus.data_write_value_in;
            end
            default: ;
        endcase

        instr_done = bus.mem_ready_in & (owner == OWN_I) & i_req;
        data_done  = bus.mem_ready_in & (owner == OWN_D) & d_req;

        bus.instr_ready_out      = instr_done;
        bus.data_ready_out       = data_done;
        bus.instr_read_value_out = bus.mem_read_value_in;
        bus.data_read_value_out  = bus.mem_read_value_in;
        bus.grant_instr_out      = (owner == OWN_I);
        bus.grant_data_out       = (owner == OWN_D);

        // Completion or withdrawal both fall back to IDLE for re-arbitration.
        next_state = IDLE;
        if (owner == OWN_I && i_req && !instr_done) begin
            next_state = OWN_I;
        end else if (owner == OWN_D && d_req && !data_done) begin
            next_state = OWN_D;
        end

        streak_next = streak;
        if (!i_req || instr_done) begin
            streak_next = '0;
        end else if (data_done && streak != MAX_STREAK) begin
            streak_next = streak + 1'b1;
        end

        dbg_state  = state;
        dbg_streak = streak;
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter: lone fetch, collision, lock,
// starvation guard, withdrawal and asynchronous reset.
module tb_rv32_bus_arbiter;
    import rv32_bus_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    rv32_bus_owner_t     dbg_state;
    logic [STREAK_W-1:0] dbg_streak;
    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic [31:0]         exp_q[$];
    logic [31:0]         got;
    bit                  done;

    rv32_bus_arbiter_if bus ();

    rv32_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .dbg_streak (dbg_streak)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2-3 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.instr_address_in    = '0;
        bus.instr_read_in       = 1'b0;
        bus.data_address_in     = '0;
        bus.data_read_in        = 1'b0;
        bus.data_write_in       = 1'b0;
        bus.data_write_mask_in  = '0;
        bus.data_write_value_in = '0;
        bus.mem_read_value_in   = '0;
        bus.mem_ready_in        = 1'b0;
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        bus.instr_address_in = addr;
        bus.instr_read_in    = 1'b1;
    endtask

    task automatic drive_data(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] val);
        bus.data_read_in        = rd;
        bus.data_write_in       = wr;
        bus.data_address_in     = addr;
        bus.data_write_mask_in  = mask;
        bus.data_write_value_in = val;
    endtask

    initial begin
        // Reset
        idle_inputs();
        reset = 1'b0;
        #12;
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        check_eq("rst_streak", 32'(dbg_streak), 32'd0);
        check_eq("rst_mem_read", 32'(bus.mem_read_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Lone fetch, memory ready after two wait cycles
        cyc();
        drive_fetch(32'h100);
        #1;
        check_eq("fetch_c0_addr", bus.mem_address_out, 32'h100);
        check_eq("fetch_c0_grant", 32'(bus.grant_instr_out), 32'd1);
        check_eq("fetch_c0_read", 32'(bus.mem_read_out), 32'd1);
        check_eq("fetch_c0_ready", 32'(bus.instr_ready_out), 32'd0);
        cyc();
        #1;
        check_eq("fetch_c1_state", 32'(dbg_state), 32'(OWN_I));
        check_eq("fetch_c1_addr", bus.mem_address_out, 32'h100);
        check_eq("fetch_c1_ready", 32'(bus.instr_ready_out), 32'd0);
        cyc();
        bus.mem_ready_in      = 1'b1;
        bus.mem_read_value_in = 32'h0000_1234;
        #1;
        check_eq("fetch_c2_ready", 32'(bus.instr_ready_out), 32'd1);
        check_eq("fetch_c2_rdata", bus.instr_read_value_out, 32'h0000_1234);
        check_eq("fetch_c2_dready", 32'(bus.data_ready_out), 32'd0);
        cyc();
        idle_inputs();
        #1;
        check_eq("fetch_c3_state", 32'(dbg_state), 32'(IDLE));
        check_eq("fetch_c3_ready", 32'(bus.instr_ready_out), 32'd0);

        // Simultaneous fetch and store, memory always ready
        cyc();
        drive_fetch(32'h200);
        drive_data(1'b0, 1'b1, 32'h8000, 4'b0011, 32'hDEAD_BEEF);
        bus.mem_ready_in = 1'b1;
        #1;
        check_eq("coll_c0_addr", bus.mem_address_out, 32'h8000);
        check_eq("coll_c0_write", 32'(bus.mem_write_out), 32'd1);
        check_eq("coll_c0_mask", 32'(bus.mem_write_mask_out), 32'h3);
        check_eq("coll_c0_wdata", bus.mem_write_value_out, 32'hDEAD_BEEF);
        check_eq("coll_c0_dready", 32'(bus.data_ready_out), 32'd1);
        check_eq("coll_c0_iready", 32'(bus.instr_ready_out), 32'd0);
        cyc();
        drive_data(1'b0, 1'b0, 32'h8000, 4'b0011, 32'hDEAD_BEEF);
        #1;
        check_eq("coll_c1_streak", 32'(dbg_streak), 32'd1);
        check_eq("coll_c1_addr", bus.mem_address_out, 32'h200);
        check_eq("coll_c1_write", 32'(bus.mem_write_out), 32'd0);
        check_eq("coll_c1_mask", 32'(bus.mem_write_mask_out), 32'h0);
        check_eq("coll_c1_iready", 32'(bus.instr_ready_out), 32'd1);
        check_eq("coll_c1_dready", 32'(bus.data_ready_out), 32'd0);
        cyc();
        idle_inputs();
        #1;
        check_eq("coll_c2_streak", 32'(dbg_streak), 32'd0);

        // Lock: a load arriving mid-fetch must wait
        cyc();
        drive_fetch(32'h300);
        #1;
        check_eq("lock_c0_grant", 32'(bus.grant_instr_out), 32'd1);
        cyc();
        drive_data(1'b1, 1'b0, 32'h9000, 4'b0000, 32'h0);
        #1;
        check_eq("lock_c1_addr", bus.mem_address_out, 32'h300);
        check_eq("lock_c1_grant_d", 32'(bus.grant_data_out), 32'd0);
        cyc();
        #1;
        check_eq("lock_c2_addr", bus.mem_address_out, 32'h300);
        cyc();
        bus.mem_ready_in = 1'b1;
        #1;
        check_eq("lock_c3_addr", bus.mem_address_out, 32'h300);
        check_eq("lock_c3_iready", 32'(bus.instr_ready_out), 32'd1);
        check_eq("lock_c3_dready", 32'(bus.data_ready_out), 32'd0);
        cyc();
        bus.instr_read_in = 1'b0;
        #1;
        check_eq("lock_c4_addr", bus.mem_address_out, 32'h9000);
        check_eq("lock_c4_dready", 32'(bus.data_ready_out), 32'd1);
        cyc();
        idle_inputs();

        // Starvation guard: four data completions, then the fetch
        exp_q = {};
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        cyc();
        drive_fetch(32'h400);
        drive_data(1'b1, 1'b0, 32'hA000, 4'b0000, 32'h0);
        bus.mem_ready_in = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            #1;
            if (bus.data_ready_out || bus.instr_ready_out) begin
                got = bus.instr_ready_out ? 32'd1 : 32'd2;
                if (exp_q.size() == 0) check_eq("starve_extra", got, 32'd0);
                else check_eq("starve_order", got, exp_q.pop_front());
            end
            if (bus.instr_ready_out) begin
                check_eq("starve_streak_sat", 32'(dbg_streak), 32'd4);
                done = 1'b1;
            end
            cyc();
        end
        check_eq("starve_done", 32'(done), 32'd1);
        check_eq("starve_q_empty", exp_q.size(), 32'd0);
        idle_inputs();
        #1;
        check_eq("starve_streak_clr", 32'(dbg_streak), 32'd0);

        // Withdraw a locked fetch; pending store takes the port
        cyc();
        drive_fetch(32'h500);
        #1;
        check_eq("wd_c0_grant", 32'(bus.grant_instr_out), 32'd1);
        cyc();
        bus.instr_read_in = 1'b0;
        drive_data(1'b0, 1'b1, 32'hB000, 4'hF, 32'h0000_0055);
        bus.mem_ready_in = 1'b1;
        #1;
        check_eq("wd_c1_state", 32'(dbg_state), 32'(OWN_I));
        check_eq("wd_c1_iready", 32'(bus.instr_ready_out), 32'd0);
        check_eq("wd_c1_dready", 32'(bus.data_ready_out), 32'd0);
        check_eq("wd_c1_read", 32'(bus.mem_read_out), 32'd0);
        cyc();
        #1;
        check_eq("wd_c2_state", 32'(dbg_state), 32'(IDLE));
        check_eq("wd_c2_grant_d", 32'(bus.grant_data_out), 32'd1);
        check_eq("wd_c2_addr", bus.mem_address_out, 32'hB000);
        check_eq("wd_c2_dready", 32'(bus.data_ready_out), 32'd1);
        check_eq("wd_c2_iready", 32'(bus.instr_ready_out), 32'd0);
        cyc();
        idle_inputs();

        // Asynchronous reset while locked in OWN_D with streak 3
        cyc();
        drive_fetch(32'h600);
        drive_data(1'b1, 1'b0, 32'hC000, 4'b0000, 32'h0);
        bus.mem_ready_in = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.mem_ready_in = 1'b0;
        cyc();
        #1;
        check_eq("ar_pre_state", 32'(dbg_state), 32'(OWN_D));
        check_eq("ar_pre_streak", 32'(dbg_streak), 32'd3);
        reset = 1'b0;
        #1;
        check_eq("ar_state", 32'(dbg_state), 32'(IDLE));
        check_eq("ar_streak", 32'(dbg_streak), 32'd0);
        idle_inputs();
        bus.mem_ready_in = 1'b1;
        #1;
        check_eq("ar_mem_addr", bus.mem_address_out, 32'h0);
        check_eq("ar_mem_read", 32'(bus.mem_read_out), 32'd0);
        check_eq("ar_mem_write", 32'(bus.mem_write_out), 32'd0);
        check_eq("ar_mem_mask", 32'(bus.mem_write_mask_out), 32'h0);
        check_eq("ar_mem_wdata", bus.mem_write_value_out, 32'h0);
        check_eq("ar_no_iready", 32'(bus.instr_ready_out), 32'd0);
        check_eq("ar_no_dready", 32'(bus.data_ready_out), 32'd0);
        check_eq("ar_no_grant", 32'({bus.grant_instr_out, bus.grant_data_out}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_bus_arbiter.md
# rv32_bus_arbiter

Shares one unified memory port between the rv32 core's instruction bus and data bus, so the core can sit on a single-ported RAM or bus bridge. Data requests win by default, because a pending data access stalls the whole pipeline. A streak counter guarantees fetch progress under sustained load/store traffic. The block sits between the `rv32` core's two bus port groups and the memory.

## Interface
- `MAX_DATA_STREAK`, default 4: maximum consecutive data completions granted while a fetch waits. Legal range is 1..255.

- `clk` input 1: clock.
- `reset` input 1: one clock; reset is asynchronous and active-low (0 = reset).
- `instr_address_in` input 32: fetch address.
- `instr_read_in` input 1: fetch request.
- `instr_read_value_out` output 32: fetch data, passed through from `mem_read_value_in`.
- `instr_ready_out` output 1: fetch completes this cycle.
- `data_address_in` input 32: load/store address.
- `data_read_in` input 1: load request.
- `data_write_in` input 1: store request.
- `data_write_mask_in` input 4: store byte enables.
- `data_write_value_in` input 32: store data.
- `data_read_value_out` output 32: load data, passed through.
- `data_ready_out` output 1: load/store completes this cycle.
- `mem_address_out` output 32: downstream address.
- `mem_read_out` output 1: downstream read.
- `mem_write_out` output 1: downstream write.
- `mem_write_mask_out` output 4: downstream byte enables.
- `mem_write_value_out` output 32: downstream store data.
- `mem_read_value_in` input 32: downstream read data.
- `mem_ready_in` input 1: downstream completes the presented access this cycle.
- `grant_instr_out` output 1: owner is the instruction bus (debug).
- `grant_data_out` output 1: owner is the data bus (debug).

## Operation
- Request definitions:
  - `i_req` = `instr_read_in`.
  - `d_req` = `data_read_in | data_write_in`.
  - Requesters hold the request and its payload stable until ready; a withdrawn request (flush) is legal.
- States: IDLE, OWN_I, OWN_D. Held in a register; reset value is IDLE.
- Owner selection:
  - In IDLE the owner is chosen combinationally as the arbitration winner.
  - In OWN_I / OWN_D the owner is locked.
- Arbitration winner:
  - I if `i_req` and `streak == MAX_DATA_STREAK`.
  - Otherwise D if `d_req`.
  - Otherwise I if `i_req`.
  - Otherwise none.
- Downstream port:
  - Driven from the owner's signals; the instruction owner drives `mem_write_out=0` and mask 0.
  - With no owner: all `mem_*` outputs are 0.
- Ready routing:
  - `instr_ready_out = mem_ready_in & owner==I & i_req`.
  - `data_ready_out = mem_ready_in & owner==D & d_req`.
  - Read values are passed through unconditionally.
- State transitions each cycle, with owner X:
  - Completion (X's ready high): next state is IDLE. The next transaction is re-arbitrated in the following cycle with no bubble.
  - Owner requesting, `mem_ready_in` low: next state is OWN_X (lock).
  - Owner's request withdrawn while locked: next state is IDLE. The downstream access is dropped that cycle; the memory tolerates aborted reads.
- Streak counter `streak`, width 8, reset 0:
  - Data completion while `i_req` is high: increment, saturating at `MAX_DATA_STREAK`.
  - Instruction completion, or `i_req` low: clear to 0.
  - Otherwise hold.

## Timing
- Zero added latency:
  - A request granted in IDLE reaches `mem_*` in the same cycle.
  - Ready and read data are combinational from `mem_ready_in`.
- The lock prevents a data request arriving mid-fetch from changing the address while memory is busy. The lower-priority requester waits until completion.
- Simultaneous first-cycle requests: D wins unless the streak is saturated.
- `mem_ready_in` with no owner: ignored, no ready pulsed.
- Asynchronous reset mid-transaction: state goes to IDLE and `streak` to 0 immediately. Outputs then follow the combinational IDLE rules.
- Only `state` and `streak` are registered.

## Structure
- Shared package `rv32_bus_pkg` holds the state typedef `rv32_bus_owner_t` (IDLE, OWN_I, OWN_D), plus the bus width constants (32-bit address/data, 4-bit mask).
- No sub-module: the mux, FSM and counter are inline in one `always_ff` and one `always_comb`.

## Test plan
- Lone fetch: `instr_read_in=1` at address 0x100, `mem_ready_in` asserted after 2 wait cycles.
  - `mem_address_out=0x100` from cycle 0 with `grant_instr_out=1`.
  - `instr_ready_out` pulses in cycle 2 only.
- Simultaneous fetch (0x200) and store (0x8000, mask 4'b0011, value 0xDEADBEEF), ready=1 every cycle:
  - Store is presented first.
  - Fetch is presented the next cycle.
  - `data_ready_out` and `instr_ready_out` each pulse once, in that order.
- Lock: fetch in OWN_I with ready low, then a load asserts.
  - `mem_address_out` stays at the fetch address until fetch completion.
  - The load is granted the following cycle.
- Starvation with `MAX_DATA_STREAK=4`: continuous data requests plus a fetch, ready=1.
  - Exactly 4 data completions, then 1 fetch completion.
  - `streak` returns to 0.
- Withdraw: `instr_read_in` dropped while in OWN_I.
  - State returns to IDLE next cycle.
  - A pending store is granted immediately.
  - No spurious `instr_ready_out`.
- Async reset asserted mid-transaction in OWN_D with streak 3:
  - `state=IDLE` and `streak=0` immediately.
  - `mem_*` outputs are 0 when no requests are active.
